// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and the control unit that
// drives it: port identifiers, arbiter FSM states and the memory map widths.
package dmem_arbiter_pkg;

    // Default widths of the 256x16 data memory.
    localparam int DMEM_AW = 8;
    localparam int DMEM_DW = 16;

    // Requester identity. It is used for arbitration history and for read-return routing.
    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_EXT = 1'b1
    } port_e;

    // Arbiter ownership mode.
    typedef enum logic {
        ST_SHARED   = 1'b0,
        ST_EXT_LOCK = 1'b1
    } arb_state_e;

    // One entry of the read-return pipeline.
    typedef struct packed {
        logic  valid;
        port_e owner;
    } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports plus the RAM-side bus around the arbiter.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
);
    logic          cpu_req;
    logic          cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          ext_req;
    logic          ext_wr;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_lock;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [DW-1:0] ext_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          locked;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ext_req, ext_wr, ext_addr, ext_wdata, ext_lock,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_addr, mem_wr, mem_wdata,
        input  mem_rdata,
        output locked
    );

    // Requester and RAM side.
    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output ext_req, ext_wr, ext_addr, ext_wdata, ext_lock,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_addr, mem_wr, mem_wdata,
        output mem_rdata,
        input  locked
    );

endinterface

// File: rtl/dmem_arbiter_rd_return_pipe.sv
// Shift register of {valid, owner} tags. It is RD_LAT deep, so a tag loaded with a read
// grant appears at the output in the same cycle that the RAM presents the data.
module dmem_arbiter_rd_return_pipe
    import dmem_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
)(
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t in_tag,
    output rd_tag_t out_tag
);

    rd_tag_t stage_q [RD_LAT];

    // Shift one stage per cycle. Reset clears every stage, so reads in flight are dropped.
    // NOTE: the pipeline array is reset on purpose. Unlike a data RAM, stale valid bits here would
    // produce phantom rvalid pulses after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_tag = stage_q[RD_LAT-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM. It grants round-robin
// between the CPU and the external port. An external burst lock is bounded by a
// watchdog that forces one CPU slot. Read data is routed back to the port that issued it.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW       = DMEM_AW,
    parameter int DW       = DMEM_DW,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 16
)(
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);

    localparam int            CW       = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

    arb_state_e    state_q, state_d;
    port_e         last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cpu_gnt, ext_gnt;

    rd_tag_t       in_tag, out_tag;
    logic          cpu_rvalid, ext_rvalid;
    logic [DW-1:0] cpu_rdata_q, ext_rdata_q;

    // Arbiter state register: the mode, the last granted port and the lock watchdog.
    // NOTE: non-blocking assignments make every flop sample the pre-edge values.
    // This keeps the state update order-independent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SHARED;
            last_q  <= PORT_EXT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Combinational grant and next-state logic.
    // NOTE: every output gets a default before the case statement. Otherwise a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SHARED: begin
                if (bus.cpu_req && bus.ext_req) begin
                    cpu_gnt = (last_q == PORT_EXT);
                    ext_gnt = (last_q == PORT_CPU);
                end else begin
                    cpu_gnt = bus.cpu_req;
                    ext_gnt = bus.ext_req;
                end
                if (ext_gnt && bus.ext_lock) begin
                    state_d = ST_EXT_LOCK;
                    cnt_d   = CW'(1);
                end
            end
            ST_EXT_LOCK: begin
                cnt_d = (cnt_q == LOCK_MAX) ? cnt_q : cnt_q + 1'b1;
                if (cnt_q == LOCK_MAX && bus.cpu_req) begin
                    // The watchdog slot gives the CPU exactly one access.
                    cpu_gnt = 1'b1;
                    state_d = ST_SHARED;
                    cnt_d   = '0;
                end else if (!bus.ext_lock) begin
                    // The lock is released. Shared rules apply with Ext as the last owner.
                    cpu_gnt = bus.cpu_req;
                    ext_gnt = bus.ext_req && !bus.cpu_req;
                    state_d = ST_SHARED;
                    cnt_d   = '0;
                end else begin
                    ext_gnt = bus.ext_req;
                end
            end
            default: begin
                state_d = ST_SHARED;
                cnt_d   = '0;
            end
        endcase

        // No access may reach the RAM while reset is asserted.
        if (!rst_n) begin
            cpu_gnt = 1'b0;
            ext_gnt = 1'b0;
        end

        last_d = last_q;
        if (cpu_gnt) begin
            last_d = PORT_CPU;
        end else if (ext_gnt) begin
            last_d = PORT_EXT;
        end
    end

    // RAM-side mux from the granted port. The bus is driven to zero when idle.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wr    = 1'b0;
        bus.mem_wdata = '0;
        if (cpu_gnt) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wr    = bus.cpu_wr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (ext_gnt) begin
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wr    = bus.ext_wr;
            bus.mem_wdata = bus.ext_wdata;
        end
    end

    // Tag each granted read with its owner for the return pipeline.
    always_comb begin
        in_tag.valid = (cpu_gnt && !bus.cpu_wr) || (ext_gnt && !bus.ext_wr);
        in_tag.owner = ext_gnt ? PORT_EXT : PORT_CPU;
    end

    dmem_arbiter_rd_return_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_tag  (in_tag),
        .out_tag (out_tag)
    );

    assign cpu_rvalid = out_tag.valid && (out_tag.owner == PORT_CPU);
    assign ext_rvalid = out_tag.valid && (out_tag.owner == PORT_EXT);

    // Hold the last returned word per port. The non-owner keeps its previous data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= bus.mem_rdata;
            if (ext_rvalid) ext_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.ext_gnt    = ext_gnt;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.ext_rvalid = ext_rvalid;
    assign bus.cpu_rdata  = cpu_rvalid ? bus.mem_rdata : cpu_rdata_q;
    assign bus.ext_rdata  = ext_rvalid ? bus.mem_rdata : ext_rdata_q;
    assign bus.locked     = (state_q == ST_EXT_LOCK);

endmodule
